sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
Memory-side responder for the SLC-3 external memory interface. It answers the CPU's active-low CE/UB/LB/OE/WE strobes and 20-bit ADDR with an on-chip word-addressed 16-bit memory, a memory-mapped switch/hex I/O location, and programmable wait states. It signals completion with a one-cycle ready pulse R for the ISDU memory states. It replaces the external SRAM plus I/O glue for simulation and on-chip builds.

Parameters:
ADDR_W, 10, memory depth is 2^ADDR_W words.
WAIT_STATES, 1, extra cycles between access start and completion (0..15).
IO_ADDR, 16'hFFFF, word address mapped to Switches (read) and Hex_Out (write).

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-low reset
CE  in  1  chip enable, active-low
UB  in  1  upper byte lane [15:8] enable, active-low
LB  in  1  lower byte lane [7:0] enable, active-low
OE  in  1  read strobe, active-low
WE  in  1  write strobe, active-low
ADDR  in  20  word address from the CPU (MAR zero-extended)
Data_From_CPU  in  16  write data
Data_To_CPU  out  16  read data, registered
Data_Drive  out  1  high while responder owns the data bus (read completing/held)
R  out  1  ready pulse, one cycle per completed access
Err  out  1  one-cycle pulse with R on an out-of-range access
Switches  in  16  board switches, read at IO_ADDR
Hex_Out  out  16  hex display register, written at IO_ADDR

Behaviour:
- Reset (Reset==0 at edge): state IDLE; Data_To_CPU=0, Data_Drive=0, R=0, Err=0, Hex_Out=0, wait counter=0. Memory array not cleared. Reset overrides everything; an access in flight is aborted and no write is committed.
- Access start (IDLE only): CE==0 and (OE==0 or WE==0). WE==0 makes it a write regardless of OE; otherwise a read. ADDR, UB, LB and Data_From_CPU are latched at the start edge. Later changes are ignored until the next access.
- States:
  - IDLE -> WAIT on start (WAIT_STATES>0), or IDLE -> DONE on start (WAIT_STATES==0).
  - WAIT counts WAIT_STATES cycles, then -> DONE.
  - DONE lasts exactly one cycle, with R=1. DONE -> HOLD.
  - HOLD stays while CE==0 and (OE==0 or WE==0). HOLD -> IDLE once CE==1 or both OE and WE are 1. A strobe held across several CPU states therefore completes exactly once.
- Latency: R is asserted WAIT_STATES+1 cycles after the start edge.
- Commit/update occurs on the edge entering DONE:
  - Read: Data_To_CPU loads the addressed word. A disabled lane (UB/LB==1) reads as 8'h00. Data_To_CPU holds its value until the next read completes.
  - Write: each enabled lane is written. UB==LB==1 writes nothing but still completes with R.
- Decode:
  - Latched ADDR == {4'h0, IO_ADDR}: reads return Switches sampled at that edge; writes update Hex_Out per lane.
  - Else if ADDR[19:ADDR_W] != 0: out of range. Read returns 16'h0000, write is ignored, Err=1 together with R.
  - Else: memory word ADDR[ADDR_W-1:0].
- Data_Drive=1 in DONE and HOLD for reads only; 0 otherwise.
- R and Err are never high outside DONE. Strobe deassertion during WAIT does not abort the access; it completes and then returns HOLD->IDLE on the next cycle.

Test Plan:
- Reset with Reset=0 for 2 cycles -> all outputs 0, state IDLE, no R, even with CE=OE=0 held.
- WAIT_STATES=1: write 16'hBEEF to 0x0012 (UB=LB=0), then read 0x0012 -> R two cycles after each start; Data_To_CPU=16'hBEEF with R; Data_Drive high in DONE/HOLD of the read only.
- Byte lanes: write 16'h1234 to 0x0003, then write 16'hABCD with UB=1 LB=0, then read with UB=0 LB=0 -> 16'h12CD. Read with UB=0 LB=1 -> 16'h1200.
- I/O: Switches=16'h00A5, read 0xFFFF -> 16'h00A5. Write 16'h3C3C to 0xFFFF -> Hex_Out=16'h3C3C; memory word 0x3FF unchanged.
- Held strobe: CE=OE=0 held for 6 cycles on 0x0001 -> exactly one R pulse. Release then reassert -> second R. Out-of-range read 0x00400 -> 16'h0000, Err with R.
- Reset mid-write: start write of 16'h5555 to 0x0007 (old value 16'h0000), assert Reset during WAIT -> after reset, read 0x0007 returns 16'h0000.

Source files
------------

// File: rtl/sram_responder_if.sv
// CPU-side external memory bus of the SLC-3: active-low strobes, word address,
// split data paths and the responder's completion signals.
interface sram_responder_if;
    logic        CE;
    logic        UB;
    logic        LB;
    logic        OE;
    logic        WE;
    logic [19:0] ADDR;
    logic [15:0] Data_From_CPU;
    logic [15:0] Data_To_CPU;
    logic        Data_Drive;
    logic        R;
    logic        Err;

    modport master (
        output CE, UB, LB, OE, WE, ADDR, Data_From_CPU,
        input  Data_To_CPU, Data_Drive, R, Err
    );

    modport slave (
        input  CE, UB, LB, OE, WE, ADDR, Data_From_CPU,
        output Data_To_CPU, Data_Drive, R, Err
    );
endinterface

// File: rtl/sram_responder.sv
// Memory-side responder for the SLC-3 bus: on-chip word memory, one switch/hex
// I/O word, programmable wait states and a single ready pulse per access.
module sram_responder #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    sram_responder_if.slave       bus,
    input  logic [15:0]           Switches,
    output logic [15:0]           Hex_Out
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int WAIT_LOAD = (WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0;

    // Zero every byte lane whose active-low enable is deasserted.
    function automatic logic [15:0] lane_mask(input logic [15:0] w, input logic ub, input logic lb);
        lane_mask = {(ub ? 8'h00 : w[15:8]), (lb ? 8'h00 : w[7:0])};
    endfunction

    logic [15:0] mem [0:(2**ADDR_W)-1];

    state_t      state_r, next_state_s;
    logic [3:0]  wait_cnt_r;
    logic [19:0] addr_r;
    logic        ub_r, lb_r, is_write_r;
    logic [15:0] wdata_r;

    logic        strobe_s;
    logic [19:0] addr_eff_s;
    logic        ub_eff_s, lb_eff_s, is_write_eff_s;
    logic [15:0] wdata_eff_s;
    logic        io_hit_s, oor_s;
    logic [ADDR_W-1:0] mem_idx_s;
    logic        enter_done_s, r_nxt_s, err_nxt_s, drive_nxt_s;
    logic [15:0] rd_word_s;

    logic        r_r, err_r, drive_r;
    logic [15:0] data_r, hex_r;

    assign strobe_s = !bus.CE && (!bus.OE || !bus.WE);

    // In IDLE the start edge uses the live bus; afterwards the latched request.
    always_comb begin
        if (state_r == ST_IDLE) begin
            addr_eff_s     = bus.ADDR;
            ub_eff_s       = bus.UB;
            lb_eff_s       = bus.LB;
            is_write_eff_s = !bus.WE;
            wdata_eff_s    = bus.Data_From_CPU;
        end else begin
            addr_eff_s     = addr_r;
            ub_eff_s       = ub_r;
            lb_eff_s       = lb_r;
            is_write_eff_s = is_write_r;
            wdata_eff_s    = wdata_r;
        end
    end

    assign io_hit_s  = (addr_eff_s == {4'h0, IO_ADDR});
    assign oor_s     = !io_hit_s && ((addr_eff_s >> ADDR_W) != 20'd0);
    assign mem_idx_s = addr_eff_s[ADDR_W-1:0];

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: a held strobe is answered once, then parked in HOLD.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (strobe_s) begin
                    next_state_s = (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE: next_state_s = ST_HOLD;
            ST_HOLD: begin
                if (strobe_s) begin
                    next_state_s = ST_HOLD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode: values the output registers take on the coming edge.
    always_comb begin
        enter_done_s = Reset && (next_state_s == ST_DONE);
        r_nxt_s      = enter_done_s;
        err_nxt_s    = enter_done_s && oor_s;
        drive_nxt_s  = Reset && !is_write_eff_s &&
                       ((next_state_s == ST_DONE) || (next_state_s == ST_HOLD));
        if (io_hit_s) begin
            rd_word_s = lane_mask(Switches, ub_eff_s, lb_eff_s);
        end else if (oor_s) begin
            rd_word_s = 16'h0000;
        end else begin
            rd_word_s = lane_mask(mem[mem_idx_s], ub_eff_s, lb_eff_s);
        end
    end

    // Request latch and wait-state counter.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            addr_r     <= 20'd0;
            ub_r       <= 1'b1;
            lb_r       <= 1'b1;
            is_write_r <= 1'b0;
            wdata_r    <= 16'h0000;
            wait_cnt_r <= 4'd0;
        end else if ((state_r == ST_IDLE) && strobe_s) begin
            addr_r     <= bus.ADDR;
            ub_r       <= bus.UB;
            lb_r       <= bus.LB;
            is_write_r <= !bus.WE;
            wdata_r    <= bus.Data_From_CPU;
            wait_cnt_r <= 4'(WAIT_LOAD);
        end else if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd0)) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end
    end

    // Memory array: not reset, written per lane only on a committed write.
    always_ff @(posedge Clk) begin
        if (enter_done_s && is_write_eff_s && !io_hit_s && !oor_s) begin
            if (!ub_eff_s) begin
                mem[mem_idx_s][15:8] <= wdata_eff_s[15:8];
            end
            if (!lb_eff_s) begin
                mem[mem_idx_s][7:0] <= wdata_eff_s[7:0];
            end
        end
    end

    // Registered outputs: ready/error pulses, read data, bus ownership, hex display.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_r     <= 1'b0;
            err_r   <= 1'b0;
            drive_r <= 1'b0;
            data_r  <= 16'h0000;
            hex_r   <= 16'h0000;
        end else begin
            r_r     <= r_nxt_s;
            err_r   <= err_nxt_s;
            drive_r <= drive_nxt_s;
            if (enter_done_s && !is_write_eff_s) begin
                data_r <= rd_word_s;
            end
            if (enter_done_s && is_write_eff_s && io_hit_s) begin
                if (!ub_eff_s) begin
                    hex_r[15:8] <= wdata_eff_s[15:8];
                end
                if (!lb_eff_s) begin
                    hex_r[7:0] <= wdata_eff_s[7:0];
                end
            end
        end
    end

    assign bus.R           = r_r;
    assign bus.Err         = err_r;
    assign bus.Data_Drive  = drive_r;
    assign bus.Data_To_CPU = data_r;
    assign Hex_Out         = hex_r;
endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder (WAIT_STATES=1, ADDR_W=10): stimulus
// queues expected completions, a negedge monitor checks every R pulse.
module tb_sram_responder;
    logic        clk;
    logic        reset;
    logic [15:0] switches;
    logic [15:0] hex_out;
    int          checks;
    int          errors;

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic        rd;
    } exp_t;
    exp_t exp_q[$];

    sram_responder_if bus ();

    sram_responder #(.ADDR_W(10), .WAIT_STATES(1), .IO_ADDR(16'hFFFF)) dut (
        .Clk      (clk),
        .Reset    (reset),
        .bus      (bus.slave),
        .Switches (switches),
        .Hex_Out  (hex_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.Err && !bus.R) begin
                chk1("err_without_r", bus.Err, 1'b0);
            end
            if (bus.R) begin
                if (exp_q.size() == 0) begin
                    chk1("unexpected_r", bus.R, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk1("err_with_r", bus.Err, e.err);
                    chk1("drive_done", bus.Data_Drive, e.rd);
                    if (e.rd) begin
                        chk16("rdata", bus.Data_To_CPU, e.data);
                    end
                end
            end
        end
    end

    task automatic idle_bus();
        bus.CE = 1'b1; bus.OE = 1'b1; bus.WE = 1'b1;
        bus.UB = 1'b1; bus.LB = 1'b1;
    endtask

    task automatic drive_req(input logic wr, input logic [19:0] a, input logic [15:0] d,
                             input logic ub, input logic lb);
        bus.CE = 1'b0; bus.WE = !wr; bus.OE = wr;
        bus.ADDR = a; bus.Data_From_CPU = d; bus.UB = ub; bus.LB = lb;
    endtask

    // One complete access: start, wait for R (bounded), release, back to IDLE.
    task automatic access(input logic wr, input logic [19:0] a, input logic [15:0] d,
                          input logic ub, input logic lb,
                          input logic [15:0] exp_data, input logic exp_err);
        int n;
        exp_t e;
        @(negedge clk);
        drive_req(wr, a, d, ub, lb);
        e.data = exp_data; e.err = exp_err; e.rd = !wr;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.R && n < 10);
        checks++;
        if (n != 2 || !bus.R) begin
            errors++;
            $display("FAIL latency: got %0d cycles (R=%b) expected 2", n, bus.R);
        end
        // Scramble the bus to show the latched request is what completes.
        bus.ADDR = 20'h00000; bus.Data_From_CPU = 16'hFFFF;
        idle_bus();
        @(negedge clk);
        chk1("drive_hold", bus.Data_Drive, !wr);
        @(negedge clk);
    endtask

    initial begin
        int rcnt;
        exp_t e;
        checks = 0;
        errors = 0;
        switches = 16'h0000;
        bus.ADDR = 20'h0; bus.Data_From_CPU = 16'h0;
        idle_bus();
        reset = 1'b0;
        bus.CE = 1'b0; bus.OE = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst_r", bus.R, 1'b0);
        chk1("rst_err", bus.Err, 1'b0);
        chk1("rst_drive", bus.Data_Drive, 1'b0);
        chk16("rst_data", bus.Data_To_CPU, 16'h0000);
        chk16("rst_hex", hex_out, 16'h0000);
        idle_bus();
        reset = 1'b1;
        @(negedge clk);

        access(1'b1, 20'h00012, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0);
        access(1'b0, 20'h00012, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b0);

        access(1'b1, 20'h00003, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0);
        access(1'b1, 20'h00003, 16'hABCD, 1'b1, 1'b0, 16'h0000, 1'b0);
        access(1'b0, 20'h00003, 16'h0000, 1'b0, 1'b0, 16'h12CD, 1'b0);
        access(1'b0, 20'h00003, 16'h0000, 1'b0, 1'b1, 16'h1200, 1'b0);

        access(1'b1, 20'h003FF, 16'h7777, 1'b0, 1'b0, 16'h0000, 1'b0);
        switches = 16'h00A5;
        access(1'b0, 20'h0FFFF, 16'h0000, 1'b0, 1'b0, 16'h00A5, 1'b0);
        access(1'b1, 20'h0FFFF, 16'h3C3C, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk16("hex_out", hex_out, 16'h3C3C);
        access(1'b0, 20'h003FF, 16'h0000, 1'b0, 1'b0, 16'h7777, 1'b0);

        // Held strobe: six cycles of CE=OE=0 must complete once.
        access(1'b1, 20'h00001, 16'h0101, 1'b0, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        drive_req(1'b0, 20'h00001, 16'h0000, 1'b0, 1'b0);
        e.data = 16'h0101; e.err = 1'b0; e.rd = 1'b1;
        exp_q.push_back(e);
        rcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.R) rcnt++;
        end
        checks++;
        if (rcnt != 1) begin
            errors++;
            $display("FAIL held_strobe: got %0d R pulses expected 1", rcnt);
        end
        idle_bus();
        repeat (2) @(negedge clk);
        access(1'b0, 20'h00001, 16'h0000, 1'b0, 1'b0, 16'h0101, 1'b0);

        access(1'b0, 20'h00400, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Reset during WAIT aborts the write.
        access(1'b1, 20'h00007, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        drive_req(1'b1, 20'h00007, 16'h5555, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk1("abort_r", bus.R, 1'b0);
        idle_bus();
        reset = 1'b1;
        @(negedge clk);
        access(1'b0, 20'h00007, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending: got %0d outstanding completions expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
